// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//   Pipelined add/subtract built from one-bit full-adder cells. The WIDTH-bit
//   operation is cut into STAGES ripple segments of CHUNK = WIDTH/STAGES bits,
//   with a register after every segment. One operation per clock, latency of
//   STAGES cycles, valid/ready handshakes on both sides.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operand beat present
//     in_ready   beat accepted this cycle (combinational from out_valid/out_ready)
//     a, b       operands
//     ci         carry-in (sub=0) / borrow-in (sub=1)
//     sub        0: a+b+ci   1: a-b-ci
//     out_valid  result beat present
//     out_ready  downstream accepts result
//     s          sum / difference (modulo 2^WIDTH)
//     co         carry-out of MSB; for sub=1, 1 means no borrow
//     ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module pipelined_carry_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   // Stage registers. Stage k holds the beat after segment k has added its
   // chunk: operands still in flight, result bits produced so far, chunk carry.
   logic             r_v   [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_res [STAGES];
   logic             r_c   [STAGES];
   logic             r_ovf;

   // Inputs seen by each segment (stage 0 from the ports, stage k from k-1).
   logic             w_v_in   [STAGES];
   logic [WIDTH-1:0] w_a_in   [STAGES];
   logic [WIDTH-1:0] w_b_in   [STAGES];
   logic [WIDTH-1:0] w_res_in [STAGES];
   logic             w_c_in   [STAGES];

   logic [CHUNK-1:0] w_sum     [STAGES];
   logic             w_co      [STAGES];
   logic             w_cmsb    [STAGES];   // carry into the chunk's top bit
   logic [WIDTH-1:0] w_res_out [STAGES];
   logic             w_advance;

   assign w_advance = !r_v[STAGES-1] || out_ready;
   assign in_ready  = w_advance;

   // Operand conditioning happens at capture: a - b - ci == a + ~b + ~ci.
   always_comb begin
      w_v_in[0]   = in_valid;
      w_a_in[0]   = a;
      w_b_in[0]   = b ^ {WIDTH{sub}};
      w_c_in[0]   = ci ^ sub;
      w_res_in[0] = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_v_in[k]   = r_v[k-1];
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_res_in[k] = r_res[k-1];
         w_c_in[k]   = r_c[k-1];
      end
   end

   // One ripple of CHUNK full adders per stage; the chunk carry only ever
   // leaves a stage through r_c.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             w_cy [CHUNK+1];
      logic [CHUNK-1:0] w_s;

      assign w_cy[0] = w_c_in[k];

      for (genvar j = 0; j < CHUNK; j++) begin : g_bit
         full_adder u_fa (
            .i_a (w_a_in[k][k*CHUNK+j]),
            .i_b (w_b_in[k][k*CHUNK+j]),
            .i_c (w_cy[j]),
            .o_s (w_s[j]),
            .o_c (w_cy[j+1])
         );
      end

      assign w_sum[k]  = w_s;
      assign w_co[k]   = w_cy[CHUNK];
      assign w_cmsb[k] = w_cy[CHUNK-1];
   end

   // Merge each stage's chunk into the result word travelling with the beat.
   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_res_out[k]                  = w_res_in[k];
         w_res_out[k][k*CHUNK +: CHUNK] = w_sum[k];
      end
   end

   // Valid bits move on every advance; data only loads with a valid beat, so
   // bubbles leave the last result on s/co/ovf untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_v[k]   <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_res[k] <= '0;
            r_c[k]   <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_v[k] <= w_v_in[k];
            if (w_v_in[k]) begin
               r_a[k]   <= w_a_in[k];
               r_b[k]   <= w_b_in[k];
               r_res[k] <= w_res_out[k];
               r_c[k]   <= w_co[k];
            end
         end
         if (w_v_in[STAGES-1]) begin
            r_ovf <= w_co[STAGES-1] ^ w_cmsb[STAGES-1];
         end
      end
   end

   assign out_valid = r_v[STAGES-1];
   assign s         = r_res[STAGES-1];
   assign co        = r_c[STAGES-1];
   assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES registered carry-chain segments, each built from the existing one-bit full-adder cell.
- Sustains one operation per clock with a latency of STAGES cycles.
- Uses valid/ready handshakes on both sides, so it drops into datapaths that apply backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments; each segment is CHUNK = WIDTH/STAGES bits wide. STAGES=1 gives a single registered ripple adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand X.
- b  input  WIDTH  operand Y.
- ci  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0 = a+b+ci; 1 = a-b-ci.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts a result.
- s  output  WIDTH  sum or difference.
- co  output  1  carry-out of the MSB; when sub=1, co=1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release):
  - All stage valid bits clear.
  - All data and carry registers clear.
  - out_valid=0, s=0, co=0, ovf=0.
  - in_ready=1 from the first cycle after release.
- Operand conditioning at capture:
  - Effective B = b XOR {WIDTH{sub}}.
  - Effective carry-in = ci XOR sub.
  - Subtraction is therefore a + ~b + ~ci = a - b - ci.
- Stage k (k=0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and effective B, plus the registered carry from stage k-1 (stage 0 uses the effective carry-in).
  - Registers the CHUNK result bits and carry-out.
  - Upper operand bits not yet consumed, and lower result bits already produced, travel alongside in shift registers.
  - Each stage has exactly one combinational ripple of CHUNK full adders; no carry crosses a register boundary combinationally.
- Pipeline advance:
  - advance = !out_valid || out_ready; all stages shift together on advance.
  - in_ready = advance, purely combinational from out_valid and out_ready.
  - Beat accepted when in_valid && in_ready.
  - Bubbles (in_valid=0 on advance) propagate as invalid stages; results never reorder.
- Latency: an accepted beat appears on s/co/ovf with out_valid=1 exactly STAGES cycles later, if no stall occurs. Throughput is 1 beat/cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, all stage registers and outputs hold, and in_ready=0. Inputs presented during a stall are not captured.
- Result fields:
  - s = low WIDTH bits of the result.
  - co = carry-out of the final stage.
  - ovf = carry-into-MSB XOR carry-out-of-MSB, computed inside the final stage.
- Outputs are registered, with no combinational path from inputs to s/co/ovf/out_valid.
- Width rules: all arithmetic is modulo 2^WIDTH. No saturation; the ovf/co flags are the only indication of range exceedance.
- Boundary conditions:
  - Simultaneous accept and emit on the same edge is legal and loses no beat.
  - Reset asserted mid-operation discards all in-flight beats; no partial result is emitted after release.
  - The sub and ci values of each beat travel with that beat; changing them on the next beat does not affect in-flight beats.

Test Plan:
- Reset check: drive rst_n=0 mid-stream with 3 beats in flight, then release -> out_valid=0, s=0, co=0, ovf=0; no stale result on the following 8 cycles.
- Add, WIDTH=8, STAGES=4: a=0xFF, b=0x01, ci=0, sub=0 -> after exactly 4 cycles s=0x00, co=1, ovf=0. Also a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1.
- Subtract, WIDTH=8: a=0x05, b=0x07, ci=0, sub=1 -> s=0xFE, co=0 (borrow). Also a=0x80, b=0x01, sub=1 -> s=0x7F, ovf=1.
- Back-to-back streaming, WIDTH=32, STAGES=4: 1000 random beats with out_ready=1 and in_valid=1 -> one result per cycle in order, all matching a reference model of {co,s} = a ± b ± ci, with ovf checked.
- Backpressure: toggle out_ready randomly with 30% low and in_valid random -> in_ready=0 whenever out_valid && !out_ready; outputs hold during stalls; no beat lost or duplicated (scoreboard count equals accept count).
- Parameter sweep: STAGES=1, STAGES=WIDTH (CHUNK=1), and WIDTH=64 with STAGES=8 -> latency equals STAGES, and carry ripples correctly across all boundaries with a=all-ones, b=0, ci=1.
